timer_multi_us: RTL and testbench
=================================

Name: timer_multi_us

Overview:
Parametrised successor to the single 1 us strobe generator. It contains one free-running microsecond prescaler shared by N_CH independent programmable down-counter channels. Each channel runs in one-shot or periodic mode and emits a single-cycle tick when its interval expires. It sits beside the game-logic FSMs and paces alien march, bullet steps, UFO spawn and sound envelopes from one 36 MHz clock.

Parameters:
CLK_FREQ_MHZ, 36, system clock in MHz; prescaler divides by this to make 1 us; must be >= 2.
N_CH, 4, number of independent timer channels; 1..16.
CNT_W, 16, width of per-channel period in microseconds; max interval is 2^CNT_W-1 us.

Ports:
i_clk_25MHz  in  1  system clock (36 MHz in this design; name kept).
i_reset  in  1  asynchronous, active-low reset.
i_start  in  N_CH  per-channel start/reload strobe, one cycle.
i_stop  in  N_CH  per-channel stop strobe, one cycle.
i_periodic  in  N_CH  mode for the channel, sampled only on start: 1 = periodic, 0 = one-shot.
i_period  in  N_CH*CNT_W  packed periods in us; channel k uses bits [k*CNT_W +: CNT_W]; sampled only on start.
o_us_tick  out  1  registered 1 us strobe, high one cycle every CLK_FREQ_MHZ cycles.
o_tick  out  N_CH  registered per-channel expiry pulse, one cycle.
o_busy  out  N_CH  channel armed/counting.

Behaviour:
- Reset (i_reset=0, asynchronous): prescaler=0, o_us_tick=0, all channels idle, remain=0, o_tick=0, o_busy=0.
- Prescaler is free-running and never gated. At each edge: if p==CLK_FREQ_MHZ-1 then p<=0 and o_us_tick<=1; else p<=p+1 and o_us_tick<=0.
- First o_us_tick is high on edge CLK_FREQ_MHZ after reset release. Its period is exactly CLK_FREQ_MHZ cycles.
- Per-channel state is IDLE/RUN, equal to o_busy. Registers: remain[CNT_W], reload[CNT_W], mode.
- Start with period P!=0 and no stop on the same edge: reload<=P, remain<=P, mode<=i_periodic, busy<=1. This is legal in IDLE or RUN; in RUN it restarts and discards the current interval.
- Start with P==0: treated as stop.
- Stop, or stop and start on the same edge: busy<=0 and no tick. Stop wins.
- In RUN, on an edge where o_us_tick==1 and there is no start or stop:
  - If remain==1: o_tick<=1; periodic reloads remain<=reload; one-shot sets busy<=0.
  - Otherwise remain<=remain-1.
- o_tick is 0 on every other edge.
- Start on the same edge as the decrement: start wins, and the channel reloads.
- Timing: the first interval after start is between (P-1)*CLK_FREQ_MHZ+1 and P*CLK_FREQ_MHZ cycles, because the prescaler phase is not synchronised. Subsequent periodic intervals are exactly P*CLK_FREQ_MHZ cycles.
- One-shot: o_busy falls on the same edge that o_tick rises.
- Channels are fully independent. Simultaneous expiries on several channels all pulse in the same cycle.
- No arithmetic wrap: remain never decrements below 1 while in RUN.
- Reset asserted mid-count returns everything to the reset values immediately. There is no pending tick afterwards.

Decomposition:
- Package timer_pkg holds:
  - US_TICK_MAX(CLK_FREQ_MHZ) helper constant;
  - mode encoding constants MODE_ONESHOT=0 and MODE_PERIODIC=1;
  - default CNT_W.
- Sub-module timer_channel: one channel's FSM, remain/reload/mode registers and tick logic. It takes the shared us_tick as input.
- The top level holds the prescaler and a generate loop of N_CH timer_channel instances.

Test Plan:
All scenarios use CLK_FREQ_MHZ=4, N_CH=4, CNT_W=8.
- Release reset, no starts -> o_us_tick high on cycles 4, 8, 12, ...; o_busy=0 and o_tick=0 throughout.
- ch0 start, P=3, one-shot, on the edge after a us_tick -> o_tick[0] is one pulse on the third following us_tick edge; o_busy[0] falls on that edge; no further ticks for 100 cycles.
- ch1 periodic P=2 -> o_tick[1] every 8 cycles for 10 pulses. ch1 stop mid-interval -> o_busy[1]=0 next edge and no further ticks.
- ch2 P=5 started; restart with P=2 after 2 us ticks -> tick occurs 2 us ticks after the restart, not at 5. Start with P=0 -> o_busy[2]=0.
- i_start[3] and i_stop[3] on the same edge -> o_busy[3]=0. Start on an expiring edge -> reload, with no tick on that edge.
- ch0 and ch1 periodic P=4 running; i_reset=0 asynchronously mid-interval -> all outputs 0 before the next clock edge. After release, no tick until a new start.

Source files
------------

// File: rtl/timer_multi_us_pkg.sv
// Shared constants and types for the multi-channel microsecond timer.
// The prescaler terminal count is derived here so the top and the bench agree on one definition.
package timer_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Last prescaler count before the 1 us strobe fires.
    function automatic int US_TICK_MAX(input int clk_freq_mhz);
        return clk_freq_mhz - 1;
    endfunction

endpackage

// File: rtl/timer_multi_us_if.sv
// Control/status bundle between the game logic and the timer block.
interface timer_multi_us_if
    import timer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = CNT_W_DEFAULT
);
    // No valid/ready pairs: i_start/i_stop are single-cycle strobes sampled on every
    // clock edge and always accepted; i_periodic/i_period only matter on a start edge.
    // o_tick and o_us_tick are single-cycle pulses; o_busy is a level.
    logic [N_CH-1:0]       i_start;
    logic [N_CH-1:0]       i_stop;
    logic [N_CH-1:0]       i_periodic;
    logic [N_CH*CNT_W-1:0] i_period;
    logic                  o_us_tick;
    logic [N_CH-1:0]       o_tick;
    logic [N_CH-1:0]       o_busy;

    modport master (
        output i_start, i_stop, i_periodic, i_period,
        input  o_us_tick, o_tick, o_busy
    );

    modport slave (
        input  i_start, i_stop, i_periodic, i_period,
        output o_us_tick, o_tick, o_busy
    );

endinterface

// File: rtl/timer_multi_us_channel.sv
// One programmable down-counter channel paced by the shared 1 us strobe.
// Stop beats start, start beats a pending decrement or expiry.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             us_tick_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o,
    output ch_state_e        state_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= CH_IDLE;
            remain_q <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        // A zero period can never expire, so it disarms the channel like a stop.
        if (stop_i || (start_i && (period_i == '0))) begin
            state_d = CH_IDLE;
        end else if (start_i) begin
            state_d  = CH_RUN;
            remain_d = period_i;
            reload_d = period_i;
            mode_d   = periodic_i;
        end else if ((state_q == CH_RUN) && us_tick_i) begin
            if (remain_q == CNT_W'(1)) begin
                tick_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    remain_d = reload_q;
                end else begin
                    state_d = CH_IDLE;
                end
            end else begin
                remain_d = remain_q - 1'b1;
            end
        end
    end

    assign tick_o  = tick_q;
    assign state_o = state_q;

endmodule

// File: rtl/timer_multi_us.sv
// Free-running 1 us prescaler feeding N_CH independent one-shot/periodic timer channels.
// The clock port keeps its historical name even though the system clock is 36 MHz.
module timer_multi_us
    import timer_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 36,
    parameter int N_CH         = 4,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic             i_clk_25MHz,
    input  logic             i_reset,
    timer_multi_us_if.slave  bus
);

    localparam int            PW     = $clog2(CLK_FREQ_MHZ);
    localparam logic [PW-1:0] P_LAST = PW'(US_TICK_MAX(CLK_FREQ_MHZ));

    logic [PW-1:0] presc_q, presc_d;
    logic          us_tick_q, us_tick_d;
    ch_state_e     ch_state [N_CH];

    always_ff @(posedge i_clk_25MHz or negedge i_reset) begin
        if (!i_reset) begin
            presc_q   <= '0;
            us_tick_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            us_tick_q <= us_tick_d;
        end
    end

    // Never gated: channels see an unsynchronised phase, which bounds the first interval.
    always_comb begin
        presc_d   = presc_q + 1'b1;
        us_tick_d = 1'b0;
        if (presc_q == P_LAST) begin
            presc_d   = '0;
            us_tick_d = 1'b1;
        end
    end

    assign bus.o_us_tick = us_tick_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i      (i_clk_25MHz),
            .rst_ni     (i_reset),
            .us_tick_i  (us_tick_q),
            .start_i    (bus.i_start[k]),
            .stop_i     (bus.i_stop[k]),
            .periodic_i (bus.i_periodic[k]),
            .period_i   (bus.i_period[k*CNT_W +: CNT_W]),
            .tick_o     (bus.o_tick[k]),
            .state_o    (ch_state[k])
        );

        assign bus.o_busy[k] = (ch_state[k] == CH_RUN);
    end

endmodule

// File: tb/tb_timer_multi_us.sv
// Directed bench for timer_multi_us: expected tick cycles are queued per channel at start time
// and retired by a negedge monitor; the prescaler strobe is checked every cycle.
`timescale 1ns/1ps
module tb_timer_multi_us;
    import timer_pkg::*;

    localparam int CLK_FREQ_MHZ = 4;
    localparam int N_CH         = 4;
    localparam int CNT_W        = 8;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_err;
    bit   mon_en;
    logic [31:0] exp_q [N_CH][$];

    timer_multi_us_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    timer_multi_us #(
        .CLK_FREQ_MHZ (CLK_FREQ_MHZ),
        .N_CH         (N_CH),
        .CNT_W        (CNT_W)
    ) dut (
        .i_clk_25MHz (clk),
        .i_reset     (rst_n),
        .bus         (bus)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc == n just after the n-th rising edge since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Edge m decrements when the strobe registered at edge m-1 is high, i.e. m % F == 1, m >= F+1.
    function automatic int first_tick(input int s, input int p);
        int m;
        m = s + 1;
        while ((m % CLK_FREQ_MHZ) != 1 || m < CLK_FREQ_MHZ + 1) m++;
        return m + CLK_FREQ_MHZ * (p - 1);
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("us_tick", bus.o_us_tick, (cyc >= CLK_FREQ_MHZ) && (cyc % CLK_FREQ_MHZ == 0));
            for (int k = 0; k < N_CH; k++) begin
                logic exp_tick;
                exp_tick = (exp_q[k].size() > 0) && (exp_q[k][0] == cyc);
                if (bus.o_tick[k] || exp_tick) begin
                    chk($sformatf("tick_ch%0d@%0d", k, cyc), bus.o_tick[k], exp_tick);
                    if (exp_tick) void'(exp_q[k].pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks (enter and leave at posedge + 1) ----------------
    task automatic wait_until(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk($sformatf("wait_until_%0d", target), (cyc >= target), 1'b1);
    endtask

    task automatic do_start(input int ch, input int p, input logic per, input int n_exp);
        int s;
        int t;
        s = cyc + 1;
        exp_q[ch].delete();
        if (p != 0) begin
            t = first_tick(s, p);
            for (int i = 0; i < n_exp; i++) exp_q[ch].push_back(t + i * CLK_FREQ_MHZ * p);
        end
        bus.i_period[ch*CNT_W +: CNT_W] = CNT_W'(p);
        bus.i_periodic[ch] = per;
        bus.i_start[ch]    = 1'b1;
        @(posedge clk); #1;
        bus.i_start[ch]    = 1'b0;
    endtask

    task automatic do_stop(input int ch, input logic with_start);
        exp_q[ch].delete();
        bus.i_period[ch*CNT_W +: CNT_W] = CNT_W'(5);
        bus.i_stop[ch]  = 1'b1;
        bus.i_start[ch] = with_start;
        @(posedge clk); #1;
        bus.i_stop[ch]  = 1'b0;
        bus.i_start[ch] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        int last;
        int m;
        n_checks = 0;
        n_err    = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        bus.i_start    = '0;
        bus.i_stop     = '0;
        bus.i_periodic = '0;
        bus.i_period   = '0;

        #22;
        chk("rst_us_tick", bus.o_us_tick, 1'b0);
        chk("rst_tick", bus.o_tick, 4'h0);
        chk("rst_busy", bus.o_busy, 4'h0);

        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Idle prescaler only
        wait_until(20);
        chk("idle_busy", bus.o_busy, 4'h0);

        // ch0 one-shot P=3 started on the edge after a us_tick
        wait_until(24);
        do_start(0, 3, MODE_ONESHOT, 1);
        t0 = exp_q[0][0];
        chk("os_t0", t0, 37);
        chk("os_busy_start", bus.o_busy[0], 1'b1);
        wait_until(t0 - 1);
        chk("os_busy_pre", bus.o_busy[0], 1'b1);
        wait_until(t0);
        chk("os_tick", bus.o_tick[0], 1'b1);
        chk("os_busy_fall", bus.o_busy[0], 1'b0);
        wait_until(t0 + 100);
        chk("os_busy_after", bus.o_busy[0], 1'b0);

        // ch1 periodic P=2, ten pulses, then stop mid-interval
        do_start(1, 2, MODE_PERIODIC, 10);
        last = exp_q[1][0] + 9 * 2 * CLK_FREQ_MHZ;
        wait_until(last + 3);
        chk("per_all_seen", exp_q[1].size(), 0);
        chk("per_busy_run", bus.o_busy[1], 1'b1);
        do_stop(1, 1'b0);
        chk("per_stop_busy", bus.o_busy[1], 1'b0);
        wait_until(cyc + 30);
        chk("per_stop_quiet", bus.o_busy[1], 1'b0);

        // ch2 P=5 restarted with P=2 after two us ticks
        do_start(2, 5, MODE_ONESHOT, 1);
        m = first_tick(cyc, 1);
        wait_until(m + CLK_FREQ_MHZ);
        do_start(2, 2, MODE_ONESHOT, 1);
        t0 = exp_q[2][0];
        wait_until(t0 + 2);
        chk("restart_seen", exp_q[2].size(), 0);
        chk("restart_busy", bus.o_busy[2], 1'b0);
        wait_until(m + 6 * CLK_FREQ_MHZ);
        do_start(2, 5, MODE_ONESHOT, 1);
        chk("p0_pre_busy", bus.o_busy[2], 1'b1);
        do_start(2, 0, MODE_ONESHOT, 0);
        chk("p0_busy", bus.o_busy[2], 1'b0);

        // ch3 start+stop together, then start on an expiring edge
        do_start(3, 3, MODE_PERIODIC, 0);
        chk("ss_pre_busy", bus.o_busy[3], 1'b1);
        do_stop(3, 1'b1);
        chk("ss_busy", bus.o_busy[3], 1'b0);
        do_start(3, 2, MODE_PERIODIC, 1);
        t0 = exp_q[3][0];
        wait_until(t0 - 1);
        do_start(3, 2, MODE_PERIODIC, 2);
        chk("exp_reload_t", exp_q[3][0], t0 + 2 * CLK_FREQ_MHZ);
        chk("exp_reload_notick", bus.o_tick[3], 1'b0);
        wait_until(t0 + 4 * CLK_FREQ_MHZ + 2);
        chk("exp_reload_seen", exp_q[3].size(), 0);
        do_stop(3, 1'b0);

        // async reset mid-interval with two periodic channels
        do_start(0, 4, MODE_PERIODIC, 50);
        do_start(1, 4, MODE_PERIODIC, 50);
        wait_until(cyc + 10);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("arst_us_tick", bus.o_us_tick, 1'b0);
        chk("arst_tick", bus.o_tick, 4'h0);
        chk("arst_busy", bus.o_busy, 4'h0);
        for (int k = 0; k < N_CH; k++) exp_q[k].delete();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_until(60);
        chk("post_rst_busy", bus.o_busy, 4'h0);

        for (int k = 0; k < N_CH; k++) chk($sformatf("drain_ch%0d", k), exp_q[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
